// File: rtl/s_axi_regfile_if.sv
// AXI4 single-beat register-slave bus bundle (AW/W/B/AR/R channels).
// The slave modport is the register bank's view; master is the initiator's view.
interface s_axi_regfile_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]     awid_i;
    logic [ADDR_WIDTH-1:0]   awaddr_i;
    logic                    awvalid_i;
    logic                    awready_o;
    logic [DATA_WIDTH-1:0]   wdata_i;
    logic [DATA_WIDTH/8-1:0] wstrb_i;
    logic                    wlast_i;
    logic                    wvalid_i;
    logic                    wready_o;
    logic [ID_WIDTH-1:0]     bid_o;
    logic [1:0]              bresp_o;
    logic                    bvalid_o;
    logic                    bready_i;
    logic [ID_WIDTH-1:0]     arid_i;
    logic [ADDR_WIDTH-1:0]   araddr_i;
    logic                    arvalid_i;
    logic                    arready_o;
    logic [ID_WIDTH-1:0]     rid_o;
    logic [DATA_WIDTH-1:0]   rdata_o;
    logic [1:0]              rresp_o;
    logic                    rlast_o;
    logic                    rvalid_o;
    logic                    rready_i;

    modport slave (
        input  awid_i, awaddr_i, awvalid_i, wdata_i, wstrb_i, wlast_i, wvalid_i,
               bready_i, arid_i, araddr_i, arvalid_i, rready_i,
        output awready_o, wready_o, bid_o, bresp_o, bvalid_o,
               arready_o, rid_o, rdata_o, rresp_o, rlast_o, rvalid_o
    );

    modport master (
        output awid_i, awaddr_i, awvalid_i, wdata_i, wstrb_i, wlast_i, wvalid_i,
               bready_i, arid_i, araddr_i, arvalid_i, rready_i,
        input  awready_o, wready_o, bid_o, bresp_o, bvalid_o,
               arready_o, rid_o, rdata_o, rresp_o, rlast_o, rvalid_o
    );
endinterface

// File: rtl/s_axi_regfile.sv
// Parametrised AXI4 single-beat register bank with ID echo and SLVERR on out-of-range access.
// Define S_AXI_REGFILE_CHECKSUM_EN to expose a read-only XOR checksum word at index NUM_REGS.
module s_axi_regfile #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    NUM_REGS    = 8,
    parameter int                    ID_WIDTH    = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             areset,
    s_axi_regfile_if.slave   bus
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFFS   = $clog2(STRB_W);
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic                  has_aw_q, has_aw_d, has_w_q, has_w_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [ID_WIDTH-1:0]   awid_q, awid_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [ID_WIDTH-1:0]   bid_q, bid_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [ADDR_WIDTH-1:0] aw_idx, ar_idx;
    logic                  aw_hs, w_hs, ar_hs, commit, aw_in_range, ar_in_range;
    logic                  unused_wlast;

    assign unused_wlast   = bus.wlast_i;
    assign bus.awready_o  = !has_aw_q && !bvalid_q;
    assign bus.wready_o   = !has_w_q && !bvalid_q;
    assign bus.arready_o  = !rvalid_q;
    assign bus.bvalid_o   = bvalid_q;
    assign bus.bresp_o    = bresp_q;
    assign bus.bid_o      = bid_q;
    assign bus.rvalid_o   = rvalid_q;
    assign bus.rlast_o    = rvalid_q;
    assign bus.rresp_o    = rresp_q;
    assign bus.rid_o      = rid_q;
    assign bus.rdata_o    = rdata_q;

    // Byte offset bits are dropped; the remaining high bits must still fall below NUM_REGS.
    assign aw_idx      = awaddr_q >> OFFS;
    assign ar_idx      = bus.araddr_i >> OFFS;
    assign aw_in_range = aw_idx < NUM_REGS_A;
    assign ar_in_range = ar_idx < NUM_REGS_A;

    assign aw_hs  = bus.awvalid_i && bus.awready_o;
    assign w_hs   = bus.wvalid_i && bus.wready_o;
    assign ar_hs  = bus.arvalid_i && bus.arready_o;
    assign commit = has_aw_q && has_w_q && !bvalid_q;

`ifdef S_AXI_REGFILE_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum;
    always_comb begin
        csum = '1;
        for (int r = 0; r < NUM_REGS; r++) csum = csum ^ regs_q[r];
    end
`endif

    always_comb begin
        has_aw_d = has_aw_q;
        has_w_d  = has_w_q;
        awaddr_d = awaddr_q;
        awid_d   = awid_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        bid_d    = bid_q;
        for (int r = 0; r < NUM_REGS; r++) regs_d[r] = regs_q[r];

        if (bvalid_q && bus.bready_i) bvalid_d = 1'b0;
        if (aw_hs) begin
            has_aw_d = 1'b1;
            awaddr_d = bus.awaddr_i;
            awid_d   = bus.awid_i;
        end
        if (w_hs) begin
            has_w_d = 1'b1;
            wdata_d = bus.wdata_i;
            wstrb_d = bus.wstrb_i;
        end
        if (commit) begin
            has_aw_d = 1'b0;
            has_w_d  = 1'b0;
            bvalid_d = 1'b1;
            bid_d    = awid_q;
            bresp_d  = aw_in_range ? RESP_OKAY : RESP_SLVERR;
            for (int r = 0; r < NUM_REGS; r++) begin
                if (aw_in_range && aw_idx == ADDR_WIDTH'(r)) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (wstrb_q[b]) regs_d[r][8*b +: 8] = wdata_q[8*b +: 8];
                    end
                end
            end
        end
    end

    // Reads sample regs_q, so a same-edge write commit is not yet visible.
    always_comb begin
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rid_d    = rid_q;
        rdata_d  = rdata_q;
        if (rvalid_q && bus.rready_i) rvalid_d = 1'b0;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rid_d    = bus.arid_i;
            if (ar_in_range) begin
                rdata_d = regs_q[ar_idx[IDX_W-1:0]];
                rresp_d = RESP_OKAY;
`ifdef S_AXI_REGFILE_CHECKSUM_EN
            end else if (ar_idx == NUM_REGS_A) begin
                rdata_d = csum;
                rresp_d = RESP_OKAY;
`endif
            end else begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
            end
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= RESET_VALUE;
            has_aw_q <= 1'b0;
            has_w_q  <= 1'b0;
            awaddr_q <= '0;
            awid_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= '0;
            bid_q    <= '0;
            rvalid_q <= 1'b0;
            rresp_q  <= '0;
            rid_q    <= '0;
            rdata_q  <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= regs_d[r];
            has_aw_q <= has_aw_d;
            has_w_q  <= has_w_d;
            awaddr_q <= awaddr_d;
            awid_q   <= awid_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
            bid_q    <= bid_d;
            rvalid_q <= rvalid_d;
            rresp_q  <= rresp_d;
            rid_q    <= rid_d;
            rdata_q  <= rdata_d;
        end
    end
endmodule

// File: tb/tb_s_axi_regfile.sv
// Directed, table-driven check of s_axi_regfile (32-bit, 8 registers) plus hand-written
// sequences for channel ordering, backpressure, same-edge read/write, checksum and async reset.
module tb_s_axi_regfile;
    logic clk = 1'b0;
    logic areset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    s_axi_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4)) bus ();

    s_axi_regfile #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(8), .ID_WIDTH(4), .RESET_VALUE(32'h0)
    ) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  id;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_b(output logic [1:0] resp, output logic [3:0] id);
        int n = 0;
        while (!bus.bvalid_o && n < 20) begin step(); n++; end
        chk("b_timeout", bus.bvalid_o, 1'b1);
        resp = bus.bresp_o;
        id   = bus.bid_o;
        bus.bready_i = 1'b1;
        step();
        bus.bready_i = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp, output logic [3:0] bid);
        int n = 0;
        bit aw_pend = 1'b1, w_pend = 1'b1, aw_fire, w_fire;
        bus.awaddr_i = addr; bus.awid_i = id; bus.awvalid_i = 1'b1;
        bus.wdata_i = data; bus.wstrb_i = strb; bus.wlast_i = 1'b1; bus.wvalid_i = 1'b1;
        while ((aw_pend || w_pend) && n < 20) begin
            aw_fire = bus.awvalid_i && bus.awready_o;
            w_fire  = bus.wvalid_i && bus.wready_o;
            step(); n++;
            if (aw_fire) begin aw_pend = 1'b0; bus.awvalid_i = 1'b0; end
            if (w_fire)  begin w_pend = 1'b0;  bus.wvalid_i = 1'b0;  end
        end
        chk("aw_w_timeout", {aw_pend, w_pend}, 2'b00);
        bus.awvalid_i = 1'b0; bus.wvalid_i = 1'b0;
        wait_b(resp, bid);
        $display("WR addr=%h id=%0d data=%h strb=%h -> bresp=%0d bid=%0d", addr, id, data, strb, resp, bid);
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [3:0] id,
                            output logic [31:0] data, output logic [1:0] resp, output logic [3:0] rid);
        int n = 0;
        bit fire = 1'b0;
        bus.araddr_i = addr; bus.arid_i = id; bus.arvalid_i = 1'b1;
        while (!fire && n < 20) begin
            fire = bus.arready_o;
            step(); n++;
        end
        bus.arvalid_i = 1'b0;
        n = 0;
        while (!bus.rvalid_o && n < 20) begin step(); n++; end
        chk("r_timeout", bus.rvalid_o, 1'b1);
        chk("rlast_eq_rvalid", bus.rlast_o, bus.rvalid_o);
        data = bus.rdata_o; resp = bus.rresp_o; rid = bus.rid_o;
        bus.rready_i = 1'b1;
        step();
        bus.rready_i = 1'b0;
        $display("RD addr=%h id=%0d -> rdata=%h rresp=%0d rid=%0d", addr, id, data, resp, rid);
    endtask

    logic [31:0] rd;
    logic [1:0]  rs;
    logic [3:0]  ri;

    initial begin
        bus.awid_i = '0; bus.awaddr_i = '0; bus.awvalid_i = 1'b0;
        bus.wdata_i = '0; bus.wstrb_i = '0; bus.wlast_i = 1'b0; bus.wvalid_i = 1'b0;
        bus.bready_i = 1'b0; bus.arid_i = '0; bus.araddr_i = '0; bus.arvalid_i = 1'b0;
        bus.rready_i = 1'b0;

        for (int i = 0; i < 8; i++)
            vecs[i] = '{1'b0, 32'(i * 4), 4'(i), 32'h0, 4'h0, 32'h0, 2'b00};
        vecs[8]  = '{1'b1, 32'h04, 4'd1, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b00};
        vecs[9]  = '{1'b0, 32'h04, 4'd2, 32'h0,        4'h0, 32'hFFFFFFFF, 2'b00};
        vecs[10] = '{1'b1, 32'h40, 4'd5, 32'h12345678, 4'hF, 32'h0,        2'b10};
        vecs[11] = '{1'b0, 32'h40, 4'd7, 32'h0,        4'h0, 32'h0,        2'b10};
        vecs[12] = '{1'b1, 32'h0C, 4'd6, 32'hAAAAAAAA, 4'h0, 32'h0,        2'b00};
        vecs[13] = '{1'b0, 32'h0C, 4'd6, 32'h0,        4'h0, 32'h0,        2'b00};
        vecs[14] = '{1'b1, 32'h1D, 4'd8, 32'h01020304, 4'hF, 32'h0,        2'b00};
        vecs[15] = '{1'b0, 32'h1C, 4'd9, 32'h0,        4'h0, 32'h01020304, 2'b00};
        vecs[16] = '{1'b1, 32'h1C, 4'hA, 32'hFF000000, 4'h8, 32'h0,        2'b00};
        vecs[17] = '{1'b0, 32'h1F, 4'hB, 32'h0,        4'h0, 32'hFF020304, 2'b00};

        // Reset state, observed while reset is still asserted.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", bus.awready_o, 1'b1);
        chk("rst_wready",  bus.wready_o,  1'b1);
        chk("rst_arready", bus.arready_o, 1'b1);
        chk("rst_bvalid",  bus.bvalid_o,  1'b0);
        chk("rst_rvalid",  bus.rvalid_o,  1'b0);
        chk("rst_rdata",   bus.rdata_o,   32'h0);
        #1 areset = 1'b1;
        step();

        for (int i = 0; i < 18; i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].id, vecs[i].data, vecs[i].strb, rs, ri);
                chk($sformatf("vec%0d_bresp", i), rs, vecs[i].exp_resp);
                chk($sformatf("vec%0d_bid", i), ri, vecs[i].id);
            end else begin
                axi_read(vecs[i].addr, vecs[i].id, rd, rs, ri);
                chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_data);
                chk($sformatf("vec%0d_rresp", i), rs, vecs[i].exp_resp);
                chk($sformatf("vec%0d_rid", i), ri, vecs[i].id);
            end
        end

        // AW one cycle ahead of W: response appears one edge after W is taken.
        bus.awaddr_i = 32'h08; bus.awid_i = 4'd3; bus.awvalid_i = 1'b1;
        step();
        bus.awvalid_i = 1'b0;
        chk("awfirst_awready_busy", bus.awready_o, 1'b0);
        bus.wdata_i = 32'hDEADBEEF; bus.wstrb_i = 4'hF; bus.wvalid_i = 1'b1;
        step();
        bus.wvalid_i = 1'b0;
        chk("awfirst_bvalid_early", bus.bvalid_o, 1'b0);
        step();
        chk("awfirst_bvalid", bus.bvalid_o, 1'b1);
        chk("awfirst_bid", bus.bid_o, 4'd3);
        chk("awfirst_bresp", bus.bresp_o, 2'b00);
        $display("WR awfirst addr=08 id=3 -> bvalid=%0d bid=%0d", bus.bvalid_o, bus.bid_o);
        bus.bready_i = 1'b1; step(); bus.bready_i = 1'b0;
        chk("awfirst_bvalid_clr", bus.bvalid_o, 1'b0);
        axi_read(32'h08, 4'd1, rd, rs, ri);
        chk("awfirst_readback", rd, 32'hDEADBEEF);

        // W ahead of AW with partial strobes over 0xFFFFFFFF.
        bus.wdata_i = 32'h11223344; bus.wstrb_i = 4'h5; bus.wvalid_i = 1'b1;
        step();
        bus.wvalid_i = 1'b0;
        chk("wfirst_wready_busy", bus.wready_o, 1'b0);
        bus.awaddr_i = 32'h04; bus.awid_i = 4'd4; bus.awvalid_i = 1'b1;
        step();
        bus.awvalid_i = 1'b0;
        chk("wfirst_bvalid_early", bus.bvalid_o, 1'b0);
        wait_b(rs, ri);
        chk("wfirst_bid", ri, 4'd4);
        axi_read(32'h04, 4'd2, rd, rs, ri);
        chk("wfirst_merge", rd, 32'hFF22FF44);

        // B backpressure: response and readies frozen while bready is low.
        bus.awaddr_i = 32'h10; bus.awid_i = 4'd9; bus.awvalid_i = 1'b1;
        bus.wdata_i = 32'h55; bus.wstrb_i = 4'hF; bus.wvalid_i = 1'b1;
        step();
        bus.awvalid_i = 1'b0; bus.wvalid_i = 1'b0;
        step();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bhold%0d_bvalid", c), bus.bvalid_o, 1'b1);
            chk($sformatf("bhold%0d_bid", c), bus.bid_o, 4'd9);
            chk($sformatf("bhold%0d_rdy", c), {bus.awready_o, bus.wready_o}, 2'b00);
            step();
        end
        bus.bready_i = 1'b1; step(); bus.bready_i = 1'b0;
        chk("bhold_release", bus.bvalid_o, 1'b0);
        $display("WR hold addr=10 id=9 released");

        // R backpressure.
        bus.araddr_i = 32'h08; bus.arid_i = 4'd4; bus.arvalid_i = 1'b1;
        step();
        bus.arvalid_i = 1'b0;
        step();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("rhold%0d_rdata", c), bus.rdata_o, 32'hDEADBEEF);
            chk($sformatf("rhold%0d_rid", c), bus.rid_o, 4'd4);
            chk($sformatf("rhold%0d_arready", c), bus.arready_o, 1'b0);
            step();
        end
        bus.rready_i = 1'b1; step(); bus.rready_i = 1'b0;
        chk("rhold_release", bus.rvalid_o, 1'b0);
        $display("RD hold addr=08 id=4 released");

        // Read accepted on the write-commit edge sees the old contents.
        bus.awaddr_i = 32'h08; bus.awid_i = 4'd5; bus.awvalid_i = 1'b1;
        bus.wdata_i = 32'h600DF00D; bus.wstrb_i = 4'hF; bus.wvalid_i = 1'b1;
        step();
        bus.awvalid_i = 1'b0; bus.wvalid_i = 1'b0;
        bus.araddr_i = 32'h08; bus.arid_i = 4'd6; bus.arvalid_i = 1'b1;
        step();
        bus.arvalid_i = 1'b0;
        chk("same_edge_bvalid", bus.bvalid_o, 1'b1);
        chk("same_edge_rvalid", bus.rvalid_o, 1'b1);
        chk("same_edge_old", bus.rdata_o, 32'hDEADBEEF);
        $display("RD same-edge addr=08 -> rdata=%h", bus.rdata_o);
        bus.bready_i = 1'b1; bus.rready_i = 1'b1; step();
        bus.bready_i = 1'b0; bus.rready_i = 1'b0;
        axi_read(32'h08, 4'd6, rd, rs, ri);
        chk("same_edge_new", rd, 32'h600DF00D);

        // Asynchronous reset in the middle of pending B and R responses.
        bus.awaddr_i = 32'h08; bus.awid_i = 4'd2; bus.awvalid_i = 1'b1;
        bus.wdata_i = 32'h77; bus.wstrb_i = 4'hF; bus.wvalid_i = 1'b1;
        bus.araddr_i = 32'h04; bus.arid_i = 4'd3; bus.arvalid_i = 1'b1;
        step();
        bus.awvalid_i = 1'b0; bus.wvalid_i = 1'b0; bus.arvalid_i = 1'b0;
        step();
        chk("mid_pre_bvalid", bus.bvalid_o, 1'b1);
        chk("mid_pre_rvalid", bus.rvalid_o, 1'b1);
        #2 areset = 1'b0;
        #1;
        chk("mid_bvalid", bus.bvalid_o, 1'b0);
        chk("mid_rvalid", bus.rvalid_o, 1'b0);
        chk("mid_readies", {bus.awready_o, bus.wready_o, bus.arready_o}, 3'b111);
        $display("RST mid-transaction -> bvalid=%0d rvalid=%0d", bus.bvalid_o, bus.rvalid_o);
        @(posedge clk);
        #2 areset = 1'b1;
        step();
        axi_read(32'h08, 4'd0, rd, rs, ri);
        chk("mid_reg_reset", rd, 32'h0);

        // Checksum word at index NUM_REGS (0x20).
        axi_write(32'h00, 4'd1, 32'h0000000F, 4'hF, rs, ri);
        axi_read(32'h20, 4'd7, rd, rs, ri);
`ifdef S_AXI_REGFILE_CHECKSUM_EN
        chk("csum_rdata", rd, 32'hFFFFFFF0);
        chk("csum_rresp", rs, 2'b00);
`else
        chk("csum_rdata", rd, 32'h0);
        chk("csum_rresp", rs, 2'b10);
`endif
        chk("csum_rid", ri, 4'd7);
        axi_write(32'h20, 4'd2, 32'h12345678, 4'hF, rs, ri);
        chk("csum_write_resp", rs, 2'b10);
        axi_read(32'h00, 4'd3, rd, rs, ri);
        chk("csum_reg0_intact", rd, 32'h0000000F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/s_axi_regfile.md
Name: s_axi_regfile

Overview:
- Parametrised AXI4 single-beat slave register bank, NUM_REGS words of DATA_WIDTH bits, byte addressed, full ID echo.
- Next generation of the fixed 7 x 32-bit AXI register block. Adds:
  - width/depth/ID parametrisation;
  - AW/W accepted in either order;
  - SLVERR for out-of-range accesses;
  - real per-register readback;
  - optional XOR checksum word.
- Sits behind the system interconnect as the counter/config register slave.

Parameters:
- DATA_WIDTH, 32, register/bus width; multiple of 8, 8..128.
- ADDR_WIDTH, 32, AXI address width.
- NUM_REGS, 8, number of registers, 1..256.
- ID_WIDTH, 4, AXI ID width.
- RESET_VALUE, 0, reset contents of every register.

Ports:
- clk  in  1  clock.
- areset  in  1  asynchronous active-low reset.
- awid_i  in  ID_WIDTH  write address ID.
- awaddr_i  in  ADDR_WIDTH  write byte address.
- awvalid_i  in  1  write address valid.
- awready_o  out  1  write address ready.
- wdata_i  in  DATA_WIDTH  write data.
- wstrb_i  in  DATA_WIDTH/8  byte strobes.
- wlast_i  in  1  ignored (single beat).
- wvalid_i  in  1  write data valid.
- wready_o  out  1  write data ready.
- bid_o  out  ID_WIDTH  response ID.
- bresp_o  out  2  write response.
- bvalid_o  out  1  response valid.
- bready_i  in  1  response ready.
- arid_i  in  ID_WIDTH  read address ID.
- araddr_i  in  ADDR_WIDTH  read byte address.
- arvalid_i  in  1  read address valid.
- arready_o  out  1  read address ready.
- rid_o  out  ID_WIDTH  read ID.
- rdata_o  out  DATA_WIDTH  read data.
- rresp_o  out  2  read response.
- rlast_o  out  1  equals rvalid_o.
- rvalid_o  out  1  read valid.
- rready_i  in  1  read ready.

Behaviour:
- Clock and reset: one clock clk; reset areset is asynchronous, active-low.
- Reset values:
  - all registers = RESET_VALUE;
  - bvalid/rvalid = 0; bresp/rresp/bid/rid/rdata = 0;
  - awready/wready/arready = 1.
- Reset mid-transaction discards any captured AW/W/AR and any pending response.
- Addressing:
  - index = addr >> log2(DATA_WIDTH/8); low byte-offset bits ignored.
  - index < NUM_REGS is in range.
- Write channel:
  - Flags has_aw/has_w; awready_o = !has_aw && !bvalid_o; wready_o = !has_w && !bvalid_o.
  - AW handshake latches awaddr and awid and sets has_aw. W handshake latches wdata and wstrb and sets has_w. Order is free; both may occur in the same cycle.
  - Commit cycle: first cycle with has_aw && has_w && !bvalid_o. In range: update bytes where wstrb=1, bresp=OKAY(00). Out of range: no write, bresp=SLVERR(10). Same edge: bvalid=1, bid=latched awid, flags cleared.
  - Latency: AW and W accepted at edge N -> register updated and bvalid high at edge N+1.
  - bvalid holds, with bid/bresp stable, until bready_i=1 at an edge. No new AW/W is accepted while bvalid=1.
- Read channel:
  - arready_o = !rvalid_o.
  - On AR handshake at edge N: at edge N+1 rvalid=1, rid=arid, rdata=register[index], rresp=OKAY. Out of range: rdata=0, rresp=SLVERR.
  - rdata/rid/rresp stable until rready_i at an edge, then rvalid=0. Next AR can be accepted one cycle later.
- Simultaneous events:
  - Read and write commit to the same register on the same edge: read returns the old value.
  - Read and write channels are fully independent.
- wstrb all-zero: OKAY response, register unchanged.

Optional Feature:
- Macro S_AXI_REGFILE_CHECKSUM_EN.
- Defined: index NUM_REGS is a read-only checksum word = all-ones XOR register[0..NUM_REGS-1], sampled at AR handshake, rresp=OKAY. Writes to it: no effect, bresp=SLVERR.
- Not defined: index NUM_REGS is out of range like any other (SLVERR, rdata 0).

Test Plan:
- Reset, DATA_WIDTH=32, NUM_REGS=8 -> all readies 1, valids 0. Reads of 0x00..0x1C return 0, OKAY.
- AW 0x08 id=3 one cycle before W 0xDEADBEEF strb=0xF -> bvalid next edge after W, bid=3, OKAY. Read 0x08 -> 0xDEADBEEF.
- W 0x11223344 strb=0x5 before AW 0x04 over prior 0xFFFFFFFF -> reg1 = 0xFF22FF44.
- Write 0x40 -> SLVERR, no register changes. Read 0x40 id=7 -> rid=7, SLVERR, rdata 0.
- Hold bready=0 for 5 cycles -> bvalid/bid stable, awready=wready=0. Hold rready=0 -> rdata stable, arready=0.
- CHECKSUM_EN with reg0=0x0000000F, others 0 -> read 0x20 = 0xFFFFFFF0. Without the macro -> SLVERR. Mid-transaction reset -> bvalid=rvalid=0 immediately.
